sync_queue_2port_mem_param: RTL and testbench
=============================================

// Module: sync_queue_2port_mem_param
// PURPOSE
//  Parametrised synchronous FIFO built on a two-port (1W/1R) memory with 1-cycle registered read.
//  Generalises the fixed 128-bit queue: configurable width/depth, occupancy count, almost-full flag, sync flush.
//  First-word-fall-through dequeue via an output staging register; sits between VTA load/store/compute stages.
// PARAMETERS
//  DATA_W   128  payload width in bits
//  DEPTH    16   total capacity in entries (>=2, power of two)
//  AFULL_TH 12   io_almost_full asserted when count >= AFULL_TH (1..DEPTH)
// PORTS
//  clock           in   1          single clock, rising edge
//  reset_n         in   1          asynchronous active-low reset
//  io_flush        in   1          synchronous clear of all contents
//  io_enq_ready    out  1          queue can accept a word this cycle
//  io_enq_valid    in   1          producer offers io_enq_bits
//  io_enq_bits     in   DATA_W     enqueue payload
//  io_deq_ready    in   1          consumer takes head this cycle
//  io_deq_valid    out  1          head word available
//  io_deq_bits     out  DATA_W     head payload (registered)
//  io_count        out  CNT_W      occupancy 0..DEPTH, CNT_W=$clog2(DEPTH+1)
//  io_almost_full  out  1          count >= AFULL_TH
// BEHAVIOUR
//  - Reset (reset_n=0, async): pointers, count, staging valid cleared; io_enq_ready=1, io_deq_valid=0,
//    io_deq_bits=0, io_count=0, io_almost_full=0. Memory contents not cleared.
//  - Enq fires on enq_valid&&enq_ready; deq fires on deq_valid&&deq_ready. All outputs registered-derived;
//    no combinational path from io_enq_* to io_deq_* or from io_deq_ready to io_enq_ready.
//  - io_enq_ready = (count < DEPTH) && !io_flush. Full: no enq accepted even if deq fires same cycle.
//  - Latency: word enqueued at cycle t into an empty queue -> io_deq_valid=1 with that word at t+1.
//  - Storage: head in staging reg; rest in RAM. Writing into empty/draining staging reg bypasses RAM;
//    otherwise write RAM at wr_ptr. When staging reg empties (or deq fires) and RAM non-empty, RAM read
//    issued so staging reg refills next edge -> back-to-back deq sustains 1 word/cycle, no bubble.
//  - Simultaneous enq+deq: count unchanged; order strictly FIFO, incl. count==1 (new word becomes head next cycle).
//  - Pointers wrap modulo DEPTH; count tracked explicitly, never derived from pointer difference alone.
//  - io_flush=1: next edge empties queue (count=0, deq_valid=0, pointers=0); enq/deq that cycle ignored.
//  - io_deq_bits holds last value while io_deq_valid=0 (stable, not meaningful).
//  - Reset mid-operation: all in-flight words lost; post-reset behaviour identical to power-up.
//  - Assertions: count <= DEPTH; no enq when count==DEPTH; no deq when count==0.
// STRUCTURE
//  - Package sync_queue_pkg: function clog2 helper, CNT_W/PTR_W localparam derivations, DEPTH/AFULL_TH checks.
//  - Sub-module sync_queue_2port_ram: DEPTH x DATA_W, write port (we, waddr, wdata), registered read port
//    (re, raddr, rdata, 1-cycle), no reset; swappable for a memory macro wrapper.
//  - Top: pointer/count control, staging register, flag generation.
// TESTING
//  1 Reset: reset_n low mid-stream with count=5 -> count=0, deq_valid=0, enq_ready=1 immediately (async).
//  2 Fill: DEPTH=16, enq 0x1..0x10 with deq_ready=0 -> count=16, enq_ready=0, almost_full set at count 12.
//  3 Drain: from full, deq_ready=1 continuous -> 0x1..0x10 one per cycle, no bubbles, then deq_valid=0.
//  4 Streaming: enq+deq every cycle from count=1 -> count stays 1, output order = input order, 1-cycle latency.
//  5 Flush: count=7, assert io_flush with enq_valid=1 -> next cycle count=0, flush-cycle word not stored.
//  6 Random: 10k cycles random valid/ready vs scoreboard model -> zero mismatches, count matches model.

Source files
------------

// File: rtl/sync_queue_pkg.sv
// Shared helpers for the parametrised sync queue: width derivations and parameter legality.
package sync_queue_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

  function automatic bit params_ok(input int depth, input int afull_th);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (afull_th >= 1) && (afull_th <= depth);
  endfunction

endpackage

// File: rtl/sync_queue_2port_ram.sv
// DEPTH x DATA_W simple dual-port memory, one write port and one registered read port (1 cycle).
// No reset so it can be swapped for a memory macro wrapper.
module sync_queue_2port_ram
  import sync_queue_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = ptr_w(DEPTH)
) (
  input  logic              i_clock,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clock) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_queue_2port_mem_param.sv
// FWFT synchronous FIFO: head word lives in a staging slot, the rest in a 1W/1R RAM.
// Enqueue into an empty queue is visible one cycle later; back-to-back dequeue runs at 1 word/cycle.
module sync_queue_2port_mem_param
  import sync_queue_pkg::*;
#(
  parameter int DATA_W   = 128,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = 12,
  localparam int CNT_W   = cnt_w(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              io_flush,
  output logic              io_enq_ready,
  input  logic              io_enq_valid,
  input  logic [DATA_W-1:0] io_enq_bits,
  input  logic              io_deq_ready,
  output logic              io_deq_valid,
  output logic [DATA_W-1:0] io_deq_bits,
  output logic [CNT_W-1:0]  io_count,
  output logic              io_almost_full
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam logic [CNT_W-1:0] L_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] L_AFULL = CNT_W'(AFULL_TH);

  if (!params_ok(DEPTH, AFULL_TH)) begin : g_bad_params
    $fatal(1, "sync_queue_2port_mem_param: DEPTH must be a power of two >= 2 and 1 <= AFULL_TH <= DEPTH");
  end

  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_head_vld;
  logic              r_head_from_ram;
  logic [DATA_W-1:0] r_stage;
  logic [DATA_W-1:0] w_ram_rdata;
  logic [CNT_W-1:0]  w_ram_cnt;
  logic              w_enq, w_deq, w_head_free, w_ram_re, w_ram_we, w_bypass;

  assign io_enq_ready = (r_count < L_DEPTH) && !io_flush;
  assign w_enq        = io_enq_valid && io_enq_ready;
  assign w_deq        = r_head_vld && io_deq_ready && !io_flush;
  // RAM is never non-empty while the head slot is empty, so RAM occupancy is simply count minus head.
  assign w_ram_cnt    = r_count - CNT_W'(r_head_vld);
  assign w_head_free  = !r_head_vld || w_deq;
  assign w_ram_re     = w_head_free && (w_ram_cnt != '0) && !io_flush;
  assign w_bypass     = w_head_free && (w_ram_cnt == '0) && w_enq;
  assign w_ram_we     = w_enq && !w_bypass;

  sync_queue_2port_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .i_clock (clock),
    .i_we    (w_ram_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (io_enq_bits),
    .i_re    (w_ram_re),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_head_vld      <= 1'b0;
      r_head_from_ram <= 1'b0;
      r_stage         <= '0;
    end else if (io_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_head_vld <= 1'b0;
    end else begin
      if (w_ram_we) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_ram_re) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
      // The RAM read register doubles as the head slot, which avoids a refill bubble.
      if (w_ram_re) begin
        r_head_vld      <= 1'b1;
        r_head_from_ram <= 1'b1;
      end else if (w_bypass) begin
        r_head_vld      <= 1'b1;
        r_head_from_ram <= 1'b0;
        r_stage         <= io_enq_bits;
      end else if (w_head_free) begin
        r_head_vld <= 1'b0;
      end
    end
  end

  assign io_deq_valid   = r_head_vld;
  assign io_deq_bits    = r_head_from_ram ? w_ram_rdata : r_stage;
  assign io_count       = r_count;
  assign io_almost_full = (r_count >= L_AFULL);

  a_count_bound: assert property (@(posedge clock) disable iff (!reset_n) r_count <= L_DEPTH);
  a_no_enq_full: assert property (@(posedge clock) disable iff (!reset_n) !(w_enq && r_count == L_DEPTH));
  a_no_deq_empty: assert property (@(posedge clock) disable iff (!reset_n) !(w_deq && r_count == '0));

endmodule

// File: tb/tb_sync_queue_2port_mem_param.sv
// Scoreboard bench for sync_queue_2port_mem_param (DATA_W=128, DEPTH=16, AFULL_TH=12).
module tb_sync_queue_2port_mem_param;

  localparam int DATA_W   = 128;
  localparam int DEPTH    = 16;
  localparam int AFULL_TH = 12;
  localparam int CNT_W    = 5;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              io_flush;
  logic              io_enq_ready;
  logic              io_enq_valid;
  logic [DATA_W-1:0] io_enq_bits;
  logic              io_deq_ready;
  logic              io_deq_valid;
  logic [DATA_W-1:0] io_deq_bits;
  logic [CNT_W-1:0]  io_count;
  logic              io_almost_full;

  int                n_checks = 0;
  int                n_errors = 0;
  int                m_count  = 0;
  logic [DATA_W-1:0] sb_q[$];

  always #5 clock = ~clock;

  sync_queue_2port_mem_param #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AFULL_TH (AFULL_TH)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .io_flush       (io_flush),
    .io_enq_ready   (io_enq_ready),
    .io_enq_valid   (io_enq_valid),
    .io_enq_bits    (io_enq_bits),
    .io_deq_ready   (io_deq_ready),
    .io_deq_valid   (io_deq_valid),
    .io_deq_bits    (io_deq_bits),
    .io_count       (io_count),
    .io_almost_full (io_almost_full)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle's inputs (called just after a rising edge), check flags and head against the model.
  task automatic cycle(input logic enq_v, input logic [DATA_W-1:0] d, input logic deq_r, input logic flush);
    logic e_fire, d_fire;
    io_enq_valid = enq_v;
    io_enq_bits  = d;
    io_deq_ready = deq_r;
    io_flush     = flush;
    @(negedge clock);
    e_fire = !flush && enq_v && (m_count < DEPTH);
    d_fire = !flush && deq_r && (m_count > 0);
    chk("count", DATA_W'(io_count), DATA_W'(m_count));
    chk("enq_ready", DATA_W'(io_enq_ready), DATA_W'((m_count < DEPTH) && !flush));
    chk("deq_valid", DATA_W'(io_deq_valid), DATA_W'(m_count > 0));
    chk("almost_full", DATA_W'(io_almost_full), DATA_W'(m_count >= AFULL_TH));
    if (d_fire) begin
      chk("deq_bits", io_deq_bits, sb_q[0]);
      void'(sb_q.pop_front());
      m_count--;
    end
    if (e_fire) begin
      sb_q.push_back(d);
      m_count++;
    end
    if (flush) begin
      sb_q.delete();
      m_count = 0;
    end
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    reset_n      = 1'b0;
    io_flush     = 1'b0;
    io_enq_valid = 1'b0;
    io_enq_bits  = '0;
    io_deq_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_deq_bits", io_deq_bits, '0);
    chk("rst_count", DATA_W'(io_count), '0);
    reset_n = 1'b1;
    cycle(0, '0, 0, 0);

    // Fill to full with the consumer stalled, then one rejected offer.
    for (int i = 1; i <= DEPTH; i++) cycle(1, DATA_W'(i), 0, 0);
    chk("full_count", DATA_W'(io_count), DATA_W'(DEPTH));
    cycle(1, DATA_W'(99), 0, 0);

    // Drain with no bubbles; final cycle sees the queue empty.
    for (int i = 0; i <= DEPTH; i++) cycle(0, '0, 1, 0);

    // Streaming at count 1.
    cycle(1, DATA_W'(32'h100), 0, 0);
    for (int i = 1; i <= 20; i++) cycle(1, DATA_W'(32'h100 + i), 1, 0);
    chk("stream_count", DATA_W'(io_count), DATA_W'(1));
    cycle(0, '0, 1, 0);

    // Flush with a simultaneous offer; that word must not be kept.
    for (int i = 0; i < 7; i++) cycle(1, DATA_W'(32'h200 + i), 0, 0);
    cycle(1, DATA_W'(32'hdead), 0, 1);
    cycle(0, '0, 0, 0);
    cycle(1, DATA_W'(32'h77), 0, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);

    // Asynchronous reset mid-stream at count 5.
    for (int i = 0; i < 5; i++) cycle(1, DATA_W'(32'h300 + i), 0, 0);
    io_enq_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_count", DATA_W'(io_count), '0);
    chk("arst_deq_valid", DATA_W'(io_deq_valid), '0);
    chk("arst_enq_ready", DATA_W'(io_enq_ready), DATA_W'(1));
    chk("arst_afull", DATA_W'(io_almost_full), '0);
    chk("arst_deq_bits", io_deq_bits, '0);
    sb_q.delete();
    m_count = 0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    cycle(0, '0, 1, 0);
    cycle(1, DATA_W'(32'h400), 1, 0);
    cycle(0, '0, 1, 0);

    // Random traffic: producer-heavy phase reaches full, then balanced phase.
    for (int i = 0; i < 10000; i++) begin
      logic ev, dr, fl;
      if (i < 5000) begin
        ev = ($urandom_range(99) < 80);
        dr = ($urandom_range(99) < 40);
      end else begin
        ev = ($urandom_range(99) < 50);
        dr = ($urandom_range(99) < 50);
      end
      fl = ($urandom_range(199) == 0);
      cycle(ev, rnd_word(), dr, fl);
    end
    for (int i = 0; i <= DEPTH; i++) cycle(0, '0, 1, 0);
    chk("final_count", DATA_W'(io_count), '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
